// File: rtl/manifest_jtag_burst.sv
// manifest_jtag_burst: JTAG USER4 access engine for the manifest ROM.
// Decodes 16-bit DR commands, prefetches the addressed ROM word for the next
// Capture-DR, and in burst mode advances the address on every capture.
// Optional status readout (opcode 0xC) is enabled by defining
// MANIFEST_BURST_STATUS_EN.
module manifest_jtag_burst #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int CMD_WIDTH  = 16
) (
  input  logic                  tck,
  input  logic                  tap_test_logic_reset,
  input  logic                  tap_ir_user_defined,
  input  logic                  tap_capture_dr,
  input  logic                  tap_shift_dr,
  input  logic                  tap_update_dr,
  input  logic                  tdi,
  output logic                  tdo,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_rd_en,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  burst_active,
  output logic                  underrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    READY = 2'd3
  } state_t;

  state_t                  state;
  logic [CMD_WIDTH-1:0]    cmd_sr;
  logic [DATA_WIDTH-1:0]   data_sr;
  logic [DATA_WIDTH-1:0]   prefetch;
  logic [3:0]              opcode;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic                    cmd_valid;

  assign opcode    = cmd_sr[CMD_WIDTH-1 -: 4];
  assign cmd_addr  = ADDR_WIDTH'(cmd_sr[CMD_WIDTH-5:0]);
  assign cmd_valid = (opcode == 4'hA) || (opcode == 4'hB);
  assign tdo       = data_sr[0];

`ifdef MANIFEST_BURST_STATUS_EN
  logic        status_pending;
  logic [31:0] status_word;

  assign status_word = {8'hA5, underrun, burst_active, state, 20'(rom_addr)};
`endif

  // Command decode, ROM fetch sequencing, capture and shift of the DR.
  always_ff @(posedge tck or posedge tap_test_logic_reset) begin
    if (tap_test_logic_reset) begin
      state        <= IDLE;
      cmd_sr       <= '0;
      data_sr      <= '0;
      prefetch     <= '0;
      rom_addr     <= '0;
      rom_rd_en    <= 1'b0;
      burst_active <= 1'b0;
      underrun     <= 1'b0;
`ifdef MANIFEST_BURST_STATUS_EN
      status_pending <= 1'b0;
`endif
    end else if (tap_ir_user_defined) begin
      if (tap_capture_dr) begin
`ifdef MANIFEST_BURST_STATUS_EN
        if (status_pending) begin
          // Status capture leaves the address alone but lets an in-flight fetch finish.
          data_sr        <= DATA_WIDTH'(status_word);
          status_pending <= 1'b0;
          underrun       <= 1'b0;
          case (state)
            FETCH: begin
              state     <= LOAD;
              rom_rd_en <= 1'b0;
            end
            LOAD: begin
              prefetch <= rom_data;
              state    <= READY;
            end
            default: ;
          endcase
        end else
`endif
        begin
          case (state)
            READY: begin
              data_sr <= prefetch;
              if (burst_active) begin
                rom_addr  <= rom_addr + ADDR_WIDTH'(1);
                state     <= FETCH;
                rom_rd_en <= 1'b1;
              end
            end
            LOAD: begin
              // Word is still on the ROM port: bypass the prefetch register.
              data_sr <= rom_data;
              if (burst_active) begin
                rom_addr  <= rom_addr + ADDR_WIDTH'(1);
                state     <= FETCH;
                rom_rd_en <= 1'b1;
              end else begin
                prefetch <= rom_data;
                state    <= READY;
              end
            end
            default: begin
              data_sr  <= '1;
              underrun <= 1'b1;
            end
          endcase
        end
      end else begin
        if (tap_shift_dr) begin
          cmd_sr  <= {tdi, cmd_sr[CMD_WIDTH-1:1]};
          data_sr <= {tdi, data_sr[DATA_WIDTH-1:1]};
        end
        if (tap_update_dr && cmd_valid) begin
          rom_addr     <= cmd_addr;
          burst_active <= (opcode == 4'hB);
          state        <= FETCH;
          rom_rd_en    <= 1'b1;
        end else begin
`ifdef MANIFEST_BURST_STATUS_EN
          if (tap_update_dr && (opcode == 4'hC))
            status_pending <= 1'b1;
`endif
          case (state)
            FETCH: begin
              state     <= LOAD;
              rom_rd_en <= 1'b0;
            end
            LOAD: begin
              prefetch <= rom_data;
              state    <= READY;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_manifest_jtag_burst.sv
// Self-checking bench for manifest_jtag_burst: ROM model, directed TAP
// sequences and randomized single/burst reads checked against expected words.
module tb_manifest_jtag_burst;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int ROM_WORDS = 1 << AW;

  logic          tck = 1'b0;
  logic          rst;
  logic          sel;
  logic          capture;
  logic          shift;
  logic          update;
  logic          tdi;
  logic          tdo;
  logic [AW-1:0] rom_addr;
  logic          rom_rd_en;
  logic [DW-1:0] rom_data;
  logic          burst_active;
  logic          underrun;

  logic [DW-1:0] rom_mem [ROM_WORDS];

  int vectors    = 0;
  int miscompares = 0;
  int rd_pulses  = 0;

  // Reference expectations
  int   exp_addr;
  logic exp_burst;
  logic exp_underrun;

  manifest_jtag_burst #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_WIDTH(16)) dut (
    .tck                  (tck),
    .tap_test_logic_reset (rst),
    .tap_ir_user_defined  (sel),
    .tap_capture_dr       (capture),
    .tap_shift_dr         (shift),
    .tap_update_dr        (update),
    .tdi                  (tdi),
    .tdo                  (tdo),
    .rom_addr             (rom_addr),
    .rom_rd_en            (rom_rd_en),
    .rom_data             (rom_data),
    .burst_active         (burst_active),
    .underrun             (underrun)
  );

  always #5 tck = ~tck;

  // Registered ROM: word appears one tck after the read strobe.
  always @(posedge tck) begin
    if (rom_rd_en) rom_data <= rom_mem[rom_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
    if (rom_rd_en === 1'b1) rd_pulses++;
  endtask

  task automatic scan_cmd(input logic [15:0] c);
    for (int i = 0; i < 16; i++) begin
      shift = 1'b1;
      tdi   = c[i];
      tick();
    end
    shift  = 1'b0;
    tdi    = 1'b0;
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  // Select-DR, Capture-DR, 32 shifts of zeros, Update-DR (opcode 0 is ignored).
  task automatic read_word(output logic [31:0] w);
    tick();
    capture = 1'b1;
    tick();
    capture = 1'b0;
    for (int i = 0; i < DW; i++) begin
      w[i]  = tdo;
      shift = 1'b1;
      tdi   = 1'b0;
      tick();
    end
    shift  = 1'b0;
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [15:0] c;
    logic        t0;
    int          a;
    int          n;
    logic        b;

    for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = $urandom;
    rom_data = '0;
    rst = 1'b1; sel = 1'b1; capture = 1'b0; shift = 1'b0; update = 1'b0; tdi = 1'b0;
    #1;
    check("reset_tdo", 32'(tdo), 32'd0);
    check("reset_addr", 32'(rom_addr), 32'd0);
    check("reset_rd_en", 32'(rom_rd_en), 32'd0);
    check("reset_burst", 32'(burst_active), 32'd0);
    check("reset_underrun", 32'(underrun), 32'd0);
    #11 rst = 1'b0;
    exp_addr = 0; exp_burst = 1'b0; exp_underrun = 1'b0;

    // Single read of word 5 via the LOAD bypass, then a repeat from prefetch
    rd_pulses = 0;
    scan_cmd(16'hA005);
    read_word(w);
    check("single_first", w, rom_mem[5]);
    read_word(w);
    check("single_repeat", w, rom_mem[5]);
    check("single_rd_pulses", 32'(rd_pulses), 32'd1);
    check("single_burst", 32'(burst_active), 32'd0);
    check("single_addr", 32'(rom_addr), 32'd5);
    exp_addr = 5;

    // Unknown opcodes change nothing
    rd_pulses = 0;
    scan_cmd(16'h5123);
    scan_cmd(16'h0000);
    check("unk_addr", 32'(rom_addr), 32'(exp_addr));
    check("unk_burst", 32'(burst_active), 32'(exp_burst));
    check("unk_rd_pulses", 32'(rd_pulses), 32'd0);
    read_word(w);
    check("unk_word", w, rom_mem[5]);

    // IR not USER4: capture/shift/update pulses leave everything untouched
    sel = 1'b0;
    t0  = tdo;
    for (int i = 0; i < 9; i++) begin
      capture = (i % 3 == 0);
      shift   = (i % 3 == 1);
      update  = (i % 3 == 2);
      tdi     = 1'($urandom);
      tick();
      check("nosel_tdo", 32'(tdo), 32'(t0));
    end
    capture = 1'b0; shift = 1'b0; update = 1'b0; tdi = 1'b0;
    check("nosel_addr", 32'(rom_addr), 32'(exp_addr));
    check("nosel_underrun", 32'(underrun), 32'd0);
    sel = 1'b1;
    read_word(w);
    check("nosel_word", w, rom_mem[5]);

    // Burst across the top of the address space
    scan_cmd(16'hB3FE);
    for (int k = 0; k < 4; k++) begin
      read_word(w);
      check("burst_word", w, rom_mem[(16'h3FE + k) % ROM_WORDS]);
      check("burst_active", 32'(burst_active), 32'd1);
    end
    check("burst_wrap_addr", 32'(rom_addr), 32'd2);

    // Reset pulse between edges in the middle of a burst
    scan_cmd(16'hB010);
    read_word(w);
    check("preRst_word", w, rom_mem[16'h010]);
    #2 rst = 1'b1;
    #1;
    check("midrst_tdo", 32'(tdo), 32'd0);
    check("midrst_addr", 32'(rom_addr), 32'd0);
    check("midrst_rd_en", 32'(rom_rd_en), 32'd0);
    check("midrst_burst", 32'(burst_active), 32'd0);
    check("midrst_underrun", 32'(underrun), 32'd0);
    #1 rst = 1'b0;
    exp_addr = 0; exp_burst = 1'b0;
    read_word(w);
    check("idle_capture", w, 32'hFFFF_FFFF);
    check("idle_underrun", 32'(underrun), 32'd1);
    exp_underrun = 1'b1;

    // Randomized single and burst commands
    for (int r = 0; r < 8; r++) begin
      a = int'($urandom_range(0, ROM_WORDS - 1));
      b = 1'($urandom_range(0, 1));
      n = int'($urandom_range(1, 4));
      c = {(b ? 4'hB : 4'hA), 2'b00, 10'(a)};
      scan_cmd(c);
      for (int k = 0; k < n; k++) begin
        read_word(w);
        check("rand_word", w, rom_mem[b ? (a + k) % ROM_WORDS : a]);
        check("rand_burst", 32'(burst_active), 32'(b));
      end
      exp_addr  = b ? (a + n) % ROM_WORDS : a;
      exp_burst = b;
      check("rand_addr", 32'(rom_addr), 32'(exp_addr));
      check("rand_underrun", 32'(underrun), 32'(exp_underrun));
    end

`ifdef MANIFEST_BURST_STATUS_EN
    // Status readout after a single read (state READY, underrun set)
    a = int'($urandom_range(0, ROM_WORDS - 1));
    scan_cmd({4'hA, 2'b00, 10'(a)});
    read_word(w);
    check("stat_pre_word", w, rom_mem[a]);
    scan_cmd(16'hC000);
    read_word(w);
    check("stat_word1", w, {8'hA5, exp_underrun, 1'b0, 2'd3, 10'd0, 10'(a)});
    scan_cmd(16'hC000);
    read_word(w);
    check("stat_word2", w, {8'hA5, 1'b0, 1'b0, 2'd3, 10'd0, 10'(a)});
    read_word(w);
    check("stat_post_word", w, rom_mem[a]);
`else
    // Without the status option, 0xC is just another ignored opcode
    scan_cmd(16'hC000);
    check("c_ignored_addr", 32'(rom_addr), 32'(exp_addr));
    check("c_ignored_burst", 32'(burst_active), 32'(exp_burst));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
